// File: rtl/regfile_write_port_ctrl.sv
// regfile_write_port_ctrl
//   Merges two write sources into the register file's single write port
//   (we3/A3/WD3): a single-cycle ALU result path and a multi-cycle slow path
//   (loads, multiply) buffered in a small FIFO. Resolves WAW ordering between
//   the two paths, drops writes to $0 and publishes a pending-write mask for
//   hazard detection.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   alu_we/alu_addr/alu_data     ALU write request (held by upstream while stalled)
//   alu_stall                    ALU request not accepted this cycle
//   slow_valid/slow_ready        slow-path valid/ready handshake
//   slow_addr/slow_data          slow-path destination and result
//   we3/A3/WD3                   registered register file write port
//   pending                      bit r: write to r queued in FIFO or on we3
//   fifo_count                   entries held in the FIFO (killed ones included)
module regfile_write_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_we,
    input  logic [ADDR_WIDTH-1:0]      alu_addr,
    input  logic [DATA_WIDTH-1:0]      alu_data,
    output logic                       alu_stall,
    input  logic                       slow_valid,
    output logic                       slow_ready,
    input  logic [ADDR_WIDTH-1:0]      slow_addr,
    input  logic [DATA_WIDTH-1:0]      slow_data,
    output logic                       we3,
    output logic [ADDR_WIDTH-1:0]      A3,
    output logic [DATA_WIDTH-1:0]      WD3,
    output logic [2**ADDR_WIDTH-1:0]   pending,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we3_q, we3_d;
    logic [ADDR_WIDTH-1:0] a3_q, a3_d;
    logic [DATA_WIDTH-1:0] wd3_q, wd3_d;

    logic full, empty, alu_go, pop, push, head_vld;

    always_comb begin
        full      = (cnt_q == FULL_CNT);
        empty     = (cnt_q == '0);
        head_vld  = !empty && vld_q[rd_ptr_q];
        alu_go    = alu_we && !full;
        alu_stall = alu_we && full;
        // A killed head frees its slot even while the ALU owns the port;
        // a live head pops only when it is the one being issued.
        pop       = !empty && (!vld_q[rd_ptr_q] || !alu_go);
        push      = slow_valid && !full && (slow_addr != '0);
        slow_ready = !full;

        addr_d   = addr_q;
        data_d   = data_q;
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        we3_d    = 1'b0;
        a3_d     = a3_q;
        wd3_d    = wd3_q;

        if (alu_go) begin
            if (alu_addr != '0) begin
                we3_d = 1'b1;
                a3_d  = alu_addr;
                wd3_d = alu_data;
                // Older queued writes to the same register are superseded.
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (addr_q[i] == alu_addr) begin
                        vld_d[i] = 1'b0;
                    end
                end
            end
        end else if (head_vld) begin
            we3_d = 1'b1;
            a3_d  = addr_q[rd_ptr_q];
            wd3_d = data_q[rd_ptr_q];
        end

        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end

        // Push is applied after the kill so a same-cycle slow result survives.
        if (push) begin
            vld_d[wr_ptr_q]  = 1'b1;
            addr_d[wr_ptr_q] = slow_addr;
            data_d[wr_ptr_q] = slow_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pending[addr_q[i]] = 1'b1;
            end
        end
        if (we3_q) begin
            pending[a3_q] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign we3        = we3_q;
    assign A3         = a3_q;
    assign WD3        = wd3_q;
    assign fifo_count = cnt_q;

endmodule

// File: tb/tb_regfile_write_port_ctrl.sv
// Testbench for regfile_write_port_ctrl: directed vectors, expected register
// file writes queued at stimulus time and checked by an independent monitor.
module tb_regfile_write_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        slow_valid;
    logic        slow_ready;
    logic [4:0]  slow_addr;
    logic [31:0] slow_data;
    logic        we3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t expq[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    regfile_write_port_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_we     (alu_we),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .slow_valid (slow_valid),
        .slow_ready (slow_ready),
        .slow_addr  (slow_addr),
        .slow_data  (slow_data),
        .we3        (we3),
        .A3         (A3),
        .WD3        (WD3),
        .pending    (pending),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        expq.push_back(e);
    endtask

    // Monitor: every write presented on the port must match the queue head.
    always @(negedge clk) begin
        if (!rst && we3) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_write: got A3=%0d WD3=%0h, expected no write", A3, WD3);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("issue_addr", 64'(A3), 64'(e.a));
                chk("issue_data", 64'(WD3), 64'(e.d));
            end
        end
    end

    task automatic drive(input logic awe, input logic [4:0] aa, input logic [31:0] ad,
                         input logic sv, input logic [4:0] sa, input logic [31:0] sd);
        alu_we     = awe;
        alu_addr   = aa;
        alu_data   = ad;
        slow_valid = sv;
        slow_addr  = sa;
        slow_data  = sd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ALU writes to 1..4 keep the port busy so four slow pushes accumulate.
    task automatic fill(input logic [4:0] base);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(k + 1), 32'h1000 + 32'(k), 1'b1, base + 5'(k), 32'h5000 + 32'(k));
            expect_wr(5'(k + 1), 32'h1000 + 32'(k));
            tick();
        end
        chk("fill_count", 64'(fifo_count), 64'd4);
        chk("fill_ready", 64'(slow_ready), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(slow_ready), 64'd1);
        chk("rst_stall", 64'(alu_stall), 64'd0);
        #10;
        rst = 1'b0;
        tick();

        // Single ALU write, then the port goes idle.
        drive(1'b1, 5'd10, 32'h28082002, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd10, 32'h28082002);
        tick();
        chk("alu_we3", 64'(we3), 64'd1);
        chk("alu_pending10", 64'(pending[10]), 64'd1);
        idle();
        tick();
        chk("alu_we3_drop", 64'(we3), 64'd0);

        // Slow path drains in order once the ALU goes quiet.
        fill(5'd20);
        chk("slow_pending", 64'(pending[23:20]), 64'hF);
        idle();
        for (int k = 0; k < 4; k++) expect_wr(5'd20 + 5'(k), 32'h5000 + 32'(k));
        repeat (4) tick();
        chk("slow_drained", 64'(fifo_count), 64'd0);
        chk("slow_ready_back", 64'(slow_ready), 64'd1);

        // Full FIFO stalls the ALU for one cycle while the head issues.
        fill(5'd20);
        drive(1'b1, 5'd5, 32'h00000005, 1'b0, 5'd0, 32'h0);
        chk("full_stall", 64'(alu_stall), 64'd1);
        expect_wr(5'd20, 32'h5000);
        tick();
        chk("full_unstall", 64'(alu_stall), 64'd0);
        expect_wr(5'd5, 32'h00000005);
        tick();
        idle();
        for (int k = 1; k < 4; k++) expect_wr(5'd20 + 5'(k), 32'h5000 + 32'(k));
        repeat (3) tick();
        chk("full_drained", 64'(fifo_count), 64'd0);

        // WAW kill: the later ALU write to 7 supersedes the queued slow one.
        drive(1'b1, 5'd8, 32'h88888888, 1'b1, 5'd7, 32'hAAAA0000);
        expect_wr(5'd8, 32'h88888888);
        tick();
        drive(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 32'h0);
        chk("waw_pending_before", 64'(pending[7]), 64'd1);
        expect_wr(5'd7, 32'h11111111);
        tick();
        chk("waw_count_killed", 64'(fifo_count), 64'd1);
        idle();
        tick();
        chk("waw_pending_after", 64'(pending[7]), 64'd0);
        chk("waw_count_after", 64'(fifo_count), 64'd0);

        // Same-cycle push and ALU write to 9: slow result is newer and survives.
        drive(1'b1, 5'd9, 32'hA1A1A1A1, 1'b1, 5'd9, 32'h5A5A5A5A);
        expect_wr(5'd9, 32'hA1A1A1A1);
        tick();
        idle();
        expect_wr(5'd9, 32'h5A5A5A5A);
        repeat (2) tick();
        chk("same_cycle_count", 64'(fifo_count), 64'd0);

        // $0 filter on both paths.
        drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        tick();
        chk("zero_alu_we3", 64'(we3), 64'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hCAFEF00D);
        tick();
        chk("zero_slow_count", 64'(fifo_count), 64'd0);
        idle();
        tick();
        chk("zero_slow_we3", 64'(we3), 64'd0);

        // Reset mid-operation with two queued entries ($0 ALU writes hold the port).
        drive(1'b1, 5'd0, 32'h0, 1'b1, 5'd30, 32'h30303030);
        tick();
        drive(1'b1, 5'd0, 32'h0, 1'b1, 5'd31, 32'h31313131);
        tick();
        chk("midrst_count_before", 64'(fifo_count), 64'd2);
        chk("midrst_pending_before", 64'(pending[31:30]), 64'd3);
        idle();
        rst = 1'b1;
        #1;
        chk("midrst_we3", 64'(we3), 64'd0);
        chk("midrst_pending", 64'(pending), 64'd0);
        chk("midrst_count", 64'(fifo_count), 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("midrst_no_issue", 64'(we3), 64'd0);

        chk("exp_queue_empty", 64'(expq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
